commit_trace_buffer: RTL and testbench

Synthesizable commit-trace capture block for the MIPS core, replacing free-running testbench probing with a buffered, parametrised record of architectural side effects. Each cycle it accepts up to two retirement events, one register-file write (GRF) and one data-memory write (DM). It enqueues them in program order into a DEPTH-entry FIFO and drains them through a valid/ready port to a bench monitor or debug UART. It sits beside the core, fed from the write-back and memory-stage write enables.

---
 rtl/commit_trace_buffer.sv | 137 +++++++++++++
 tb/tb_commit_trace_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: buffers GRF and DM write retirements in program order
// and drains them through a valid/ready port with show-ahead head outputs.
//
// Ports:
//   clk, reset (async, active-low), clr (sync flush)
//   grf_we/grf_pc/grf_addr/grf_data : register-file write event
//   dm_we/dm_pc/dm_addr/dm_data     : data-memory store event
//   tr_valid/tr_ready/tr_kind/tr_pc/tr_addr/tr_data : head entry handshake
//   count    : current occupancy
//   overflow : sticky drop indicator
//   drop_cnt : saturating count of dropped events
//
// Build option: TRACE_FILTER_ZERO_EN discards GRF writes to register $0
// before they reach the push logic (not stored, not counted as drops).
module commit_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       grf_we,
    input  logic [PC_W-1:0]            grf_pc,
    input  logic [4:0]                 grf_addr,
    input  logic [DATA_W-1:0]          grf_data,
    input  logic                       dm_we,
    input  logic [PC_W-1:0]            dm_pc,
    input  logic [31:0]                dm_addr,
    input  logic [DATA_W-1:0]          dm_data,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic                       tr_kind,
    output logic [PC_W-1:0]            tr_pc,
    output logic [31:0]                tr_addr,
    output logic [DATA_W-1:0]          tr_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic              kind;
        logic [PC_W-1:0]   pc;
        logic [31:0]       addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;

    logic            pop;
    logic            grf_ev;
    logic [CW-1:0]   space;
    logic            acc_grf;
    logic            acc_dm;
    logic [1:0]      drops;
    logic [16:0]     drop_sum;
    logic [AW-1:0]   dm_slot;
    entry_t          grf_entry;
    entry_t          dm_entry;
    entry_t          head;

    // Optional suppression of writes to the hardwired-zero register.
`ifdef TRACE_FILTER_ZERO_EN
    assign grf_ev = grf_we && (grf_addr != 5'd0);
`else
    assign grf_ev = grf_we;
`endif

    // Push/drop arbitration: GRF takes the first free slot, DM the next.
    always_comb begin
        pop       = tr_valid && tr_ready;
        space     = CW'(DEPTH) - count + CW'(pop);
        acc_grf   = grf_ev && (space >= CW'(1));
        acc_dm    = dm_we && (space >= (acc_grf ? CW'(2) : CW'(1)));
        drops     = 2'(grf_ev && !acc_grf) + 2'(dm_we && !acc_dm);
        drop_sum  = {1'b0, drop_cnt} + 17'(drops);
        dm_slot   = AW'(wptr + AW'(acc_grf));
        grf_entry = '{kind: 1'b0, pc: grf_pc, addr: 32'(grf_addr), data: grf_data};
        dm_entry  = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_data};
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (acc_grf) mem[wptr]    <= grf_entry;
            if (acc_dm)  mem[dm_slot] <= dm_entry;
        end
    end

    // Pointers, occupancy and drop bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wptr  <= AW'(wptr + AW'(acc_grf) + AW'(acc_dm));
            rptr  <= AW'(rptr + AW'(pop));
            count <= CW'(count + CW'(acc_grf) + CW'(acc_dm) - CW'(pop));
            if (drops != 2'd0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    // Show-ahead head; fields forced to zero while empty.
    always_comb begin
        head     = mem[rptr];
        tr_valid = (count != '0);
        tr_kind  = 1'b0;
        tr_pc    = '0;
        tr_addr  = '0;
        tr_data  = '0;
        if (tr_valid) begin
            tr_kind = head.kind;
            tr_pc   = head.pc;
            tr_addr = head.addr;
            tr_data = head.data;
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed self-checking bench for commit_trace_buffer.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        grf_we;
    logic [31:0] grf_pc;
    logic [4:0]  grf_addr;
    logic [31:0] grf_data;
    logic        dm_we;
    logic [31:0] dm_pc;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic        tr_valid;
    logic        tr_ready;
    logic        tr_kind;
    logic [31:0] tr_pc;
    logic [31:0] tr_addr;
    logic [31:0] tr_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    commit_trace_buffer #(.DEPTH(16), .PC_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind),
        .tr_pc(tr_pc), .tr_addr(tr_addr), .tr_data(tr_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_grf(input logic we, input logic [31:0] pc, input logic [4:0] a,
                           input logic [31:0] d);
        grf_we = we; grf_pc = pc; grf_addr = a; grf_data = d;
    endtask

    task automatic set_dm(input logic we, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] d);
        dm_we = we; dm_pc = pc; dm_addr = a; dm_data = d;
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; tr_ready = 1'b0;
        set_grf(1'b1, 32'h100, 5'd3, 32'h1);
        set_dm(1'b0, '0, '0, '0);

        // Reset held with a pending GRF event: nothing may be captured.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_valid", 64'(tr_valid), 64'd0);
            check("rst_count", 64'(count), 64'd0);
            check("rst_drop", 64'(drop_cnt), 64'd0);
        end
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_pc", 64'(tr_pc), 64'd0);
        reset = 1'b1;
        set_grf(1'b0, '0, '0, '0);
        step();
        check("idle_count", 64'(count), 64'd0);

        // Dual push, GRF ahead of DM.
        set_grf(1'b1, 32'h3000, 5'd8, 32'h12);
        set_dm(1'b1, 32'h3004, 32'h10, 32'h34);
        step();
        set_grf(1'b0, '0, '0, '0);
        set_dm(1'b0, '0, '0, '0);
        check("dual_count", 64'(count), 64'd2);
        check("dual_h0_kind", 64'(tr_kind), 64'd0);
        check("dual_h0_addr", 64'(tr_addr), 64'd8);
        check("dual_h0_pc", 64'(tr_pc), 64'h3000);
        check("dual_h0_data", 64'(tr_data), 64'h12);
        tr_ready = 1'b1;
        step();
        check("dual_h1_kind", 64'(tr_kind), 64'd1);
        check("dual_h1_addr", 64'(tr_addr), 64'h10);
        check("dual_h1_pc", 64'(tr_pc), 64'h3004);
        check("dual_h1_data", 64'(tr_data), 64'h34);
        check("dual_h1_count", 64'(count), 64'd1);
        step();
        check("dual_empty_valid", 64'(tr_valid), 64'd0);
        check("dual_empty_data", 64'(tr_data), 64'd0);

        // Nine dual pushes into 16 slots: cycles 1..8 fit, cycle 9 drops both.
        tr_ready = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            set_grf(1'b1, 32'h4000 + 32'(c * 16), 5'(c), 32'(c));
            set_dm(1'b1, 32'h4004 + 32'(c * 16), 32'h100 + 32'(c * 4), 32'(c + 100));
            step();
        end
        check("ovf_count", 64'(count), 64'd16);
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_head_pc", 64'(tr_pc), 64'h4010);

        // Full with pop and dual push: GRF stored, DM dropped.
        tr_ready = 1'b1;
        set_grf(1'b1, 32'h5000, 5'd10, 32'hA);
        set_dm(1'b1, 32'h5004, 32'h200, 32'hB);
        step();
        set_grf(1'b0, '0, '0, '0);
        set_dm(1'b0, '0, '0, '0);
        check("fullpop_count", 64'(count), 64'd16);
        check("fullpop_drop", 64'(drop_cnt), 64'd3);

        // Drain: DM1, G2, D2, ..., G8, D8, then the GRF stored while full.
        for (int k = 0; k < 16; k++) begin
            logic [31:0] epc;
            logic        ekind;
            if (k == 15) begin
                epc = 32'h5000; ekind = 1'b0;
            end else begin
                ekind = (k % 2 == 0);
                epc = 32'h4000 + 32'(((k + 3) / 2) * 16) + (ekind ? 32'h4 : 32'h0);
            end
            check($sformatf("drain%0d_kind", k), 64'(tr_kind), 64'(ekind));
            check($sformatf("drain%0d_pc", k), 64'(tr_pc), 64'(epc));
            step();
        end
        check("drain_count", 64'(count), 64'd0);
        check("drain_ovf", 64'(overflow), 64'd1);

        // Flush a partly filled FIFO with a concurrent GRF event.
        tr_ready = 1'b0;
        set_grf(1'b1, 32'h5100, 5'd4, 32'h44);
        set_dm(1'b1, 32'h5104, 32'h300, 32'h45);
        step();
        check("pre_clr_count", 64'(count), 64'd2);
        set_dm(1'b0, '0, '0, '0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_grf(1'b0, '0, '0, '0);
        check("clr_count", 64'(count), 64'd0);
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_drop", 64'(drop_cnt), 64'd0);
        check("clr_valid", 64'(tr_valid), 64'd0);
        step();
        check("post_clr_count", 64'(count), 64'd0);

        // Register $0 write into an empty FIFO with ready held high.
        tr_ready = 1'b1;
        set_grf(1'b1, 32'h6000, 5'd0, 32'h55);
        step();
        set_grf(1'b0, '0, '0, '0);
`ifdef TRACE_FILTER_ZERO_EN
        check("zero_count", 64'(count), 64'd0);
        check("zero_valid", 64'(tr_valid), 64'd0);
`else
        check("zero_count", 64'(count), 64'd1);
        check("zero_addr", 64'(tr_addr), 64'd0);
        check("zero_pc", 64'(tr_pc), 64'h6000);
        check("zero_data", 64'(tr_data), 64'h55);
`endif
        step();
        check("zero_drained", 64'(count), 64'd0);

        // Asynchronous reset mid-operation, then push on first edge after release.
        tr_ready = 1'b0;
        set_grf(1'b1, 32'h7000, 5'd5, 32'h77);
        step();
        check("mid_pre_count", 64'(count), 64'd1);
        set_grf(1'b0, '0, '0, '0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(tr_valid), 64'd0);
        step();
        reset = 1'b1;
        set_grf(1'b1, 32'h7100, 5'd6, 32'h88);
        step();
        set_grf(1'b0, '0, '0, '0);
        check("mid_rel_count", 64'(count), 64'd1);
        check("mid_rel_pc", 64'(tr_pc), 64'h7100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
